mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Arbitrates the single data_memory bus (bus_addr/bus_data/read/write) between two masters:
//  m0 = cpu, m1 = loader/DMA. Sequences each access over a fixed number of bus cycles,
//  returns read data with a one-cycle ack, and keeps saturating read/write counters for the bench.
// PARAMETERS
//  ADDR_WIDTH     20  address width of bus_addr and master addresses
//  DATA_WIDTH     16  data width of bus_data, wdata and rdata
//  ACCESS_CYCLES  2   cycles read/write stay asserted per transaction (>=1)
// PORTS
//  clk          in   1           system clock, rising edge
//  reset        in   1           asynchronous, active-high
//  m0_req       in   1           m0 request; held high until m0_ack
//  m0_we        in   1           m0 1=write, 0=read
//  m0_lock      in   1           m0 keeps the bus for its next request (read-modify-write)
//  m0_addr      in   ADDR_WIDTH  m0 address
//  m0_wdata     in   DATA_WIDTH  m0 write data
//  m0_ack       out  1           one-cycle completion pulse for m0
//  m1_req/m1_we/m1_lock/m1_addr/m1_wdata/m1_ack   same as m0, for m1
//  rdata        out  DATA_WIDTH  read data, valid in the m*_ack cycle
//  grant        out  2           one-hot owner of the current transaction, 0 when idle
//  busy         out  1           high in ACCESS and RESP
//  bus_addr     out  ADDR_WIDTH  memory address
//  bus_data     inout DATA_WIDTH driven with wdata during write ACCESS, else 'z
//  read         out  1           memory read strobe
//  write        out  1           memory write strobe
//  cnt_clear    in   1           synchronous clear of both counters
//  read_count   out  32          completed read transactions, saturating
//  write_count  out  32          completed write transactions, saturating
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; grant=0, acks=0, read=write=0, bus_addr=0, bus_data='z,
//   rdata=0, counts=0, busy=0, last_owner=m1 (so m0 wins first tie), lock_owner=none.
//  All outputs registered except bus_data tri-state enable (= write).
//  FSM IDLE -> ACCESS -> RESP -> IDLE:
//   IDLE: at edge with any req: pick winner, latch we/addr/wdata, grant=winner, assert read or
//    write and bus_addr, cnt=0, go ACCESS. No req: stay, strobes low.
//   Winner: lock_owner if set and its req high; else sole requester; else both -> master != last_owner.
//   If lock_owner set but its req low in IDLE: clear lock_owner, arbitrate normally.
//   ACCESS: strobes held exactly ACCESS_CYCLES cycles; addr/wdata stable. At the edge ending the
//    last ACCESS cycle: capture bus_data into rdata (reads only), drop strobes, pulse ack, go RESP.
//   RESP: ack of owner high this cycle only; last_owner<=owner; lock_owner<=owner if its lock
//    high else none; increment read_count or write_count; grant<=0; go IDLE.
//  Latency: req seen at edge T -> strobes cycles T..T+ACCESS_CYCLES-1, ack cycle T+ACCESS_CYCLES;
//   transaction occupies ACCESS_CYCLES+2 cycles incl. the IDLE arbitration cycle.
//  rdata holds last read value until next read completes; unchanged by writes.
//  req dropped during ACCESS: transaction still completes, acked and counted (contract violation).
//  req still high in the IDLE following ack: treated as a new request.
//  Counters saturate at 32'hFFFF_FFFF; cnt_clear same cycle as increment -> result 0 (clear wins).
//  Reset mid-ACCESS: strobes drop immediately, bus released, no ack, no count.
// TESTING
//  1 m0 read addr 0x00010 (mem=0x1234), ACCESS_CYCLES=2 -> read high 2 cycles, m0_ack cycle 3, rdata=0x1234, read_count=1.
//  2 m0 and m1 req same edge after reset -> m0 first, m1 next; both pending again -> alternation m0,m1,m0.
//  3 m1 lock=1 read 0x00100 then write 0x00100=0xBEEF while m0 req high -> m1 write wins, m0 after, mem[0x100]=0xBEEF.
//  4 reset asserted mid-ACCESS of m0 write -> write drops same cycle, no m0_ack, write_count=0, bus_data='z.
//  5 force write_count=32'hFFFF_FFFF, one more write -> stays FFFF_FFFF; cnt_clear with write completing -> 0.
//  6 m0 drops req during ACCESS -> m0_ack still pulses once, read_count increments by 1.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared data-memory bus (m0 = cpu, m1 = loader/DMA).
// Each access holds the strobes for ACCESS_CYCLES cycles, then acks the owner for one cycle.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH    = 20,
  parameter int DATA_WIDTH    = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  output logic                  read,
  output logic                  write,
  input  logic                  cnt_clear,
  output logic [31:0]           read_count,
  output logic [31:0]           write_count
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate pending requests
  // ACCESS | strobes, address and write data presented to memory
  // RESP   | owner acked; bookkeeping of owner/lock/counters
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            grant_q, grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic [1:0]            ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  last_owner_q, last_owner_d;
  logic                  lock_valid_q, lock_valid_d;
  logic                  lock_id_q, lock_id_d;
  logic [31:0]           read_count_q, read_count_d;
  logic [31:0]           write_count_q, write_count_d;

  logic lock_hit;
  logic winner;
  logic owner_lock;

  always_comb begin
    lock_hit = lock_valid_q && (lock_id_q ? m1_req : m0_req);
    // Lock holder wins outright; otherwise a tie goes to whoever did not own the bus last.
    if (lock_hit)                winner = lock_id_q;
    else if (m0_req && !m1_req)  winner = 1'b0;
    else if (m1_req && !m0_req)  winner = 1'b1;
    else                         winner = ~last_owner_q;
    owner_lock = grant_q[1] ? m1_lock : m0_lock;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    read_d        = read_q;
    write_d       = write_q;
    ack_d         = 2'b00;
    rdata_d       = rdata_q;
    busy_d        = busy_q;
    last_owner_d  = last_owner_q;
    lock_valid_d  = lock_valid_q;
    lock_id_d     = lock_id_q;
    read_count_d  = read_count_q;
    write_count_d = write_count_q;

    case (state_q)
      IDLE: begin
        if (lock_valid_q && !lock_hit) lock_valid_d = 1'b0;
        if (m0_req || m1_req) begin
          grant_d = winner ? 2'b10 : 2'b01;
          we_d    = winner ? m1_we    : m0_we;
          addr_d  = winner ? m1_addr  : m0_addr;
          wdata_d = winner ? m1_wdata : m0_wdata;
          read_d  = ~we_d;
          write_d = we_d;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          if (!we_q) rdata_d = bus_data;
          read_d  = 1'b0;
          write_d = 1'b0;
          ack_d   = grant_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        last_owner_d = grant_q[1];
        lock_valid_d = owner_lock;
        lock_id_d    = grant_q[1];
        if (we_q) begin
          if (write_count_q != 32'hFFFF_FFFF) write_count_d = write_count_q + 32'd1;
        end else begin
          if (read_count_q != 32'hFFFF_FFFF) read_count_d = read_count_q + 32'd1;
        end
        grant_d = 2'b00;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        grant_d = 2'b00;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (cnt_clear) begin
      read_count_d  = 32'd0;
      write_count_d = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      grant_q       <= 2'b00;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      ack_q         <= 2'b00;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
      last_owner_q  <= 1'b1;
      lock_valid_q  <= 1'b0;
      lock_id_q     <= 1'b0;
      read_count_q  <= 32'd0;
      write_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      read_q        <= read_d;
      write_q       <= write_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
      busy_q        <= busy_d;
      last_owner_q  <= last_owner_d;
      lock_valid_q  <= lock_valid_d;
      lock_id_q     <= lock_id_d;
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
    end
  end

  // The write strobe doubles as the bus_data driver enable.
  assign bus_data    = write_q ? wdata_q : {DATA_WIDTH{1'bz}};

  assign m0_ack      = ack_q[0];
  assign m1_ack      = ack_q[1];
  assign rdata       = rdata_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign bus_addr    = addr_q;
  assign read        = read_q;
  assign write       = write_q;
  assign read_count  = read_count_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small behavioural memory on the shared bus.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_lock;
  logic [19:0] m0_addr;
  logic [15:0] m0_wdata;
  logic        m0_ack;
  logic        m1_req, m1_we, m1_lock;
  logic [19:0] m1_addr;
  logic [15:0] m1_wdata;
  logic        m1_ack;
  logic [15:0] rdata;
  logic [1:0]  grant;
  logic        busy;
  logic [19:0] bus_addr;
  wire  [15:0] bus_data;
  logic        read, write;
  logic        cnt_clear;
  logic [31:0] read_count, write_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [0:1023];
  logic [1:0]  who;

  mem_bus_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .ACCESS_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .rdata(rdata), .grant(grant), .busy(busy), .bus_addr(bus_addr),
    .bus_data(bus_data), .read(read), .write(write),
    .cnt_clear(cnt_clear), .read_count(read_count), .write_count(write_count)
  );

  assign bus_data = read ? mem[bus_addr[9:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (write) mem[bus_addr[9:0]] <= bus_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output logic [1:0] w);
    w = 2'b00;
    for (int i = 0; i < 20 && w == 2'b00; i++) begin
      tick();
      w = {m1_ack, m0_ack};
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    cnt_clear = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h010] = 16'h1234;
    mem[10'h100] = 16'h5555;
    mem[10'h020] = 16'h00A5;

    do_reset();
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_strobes", {30'd0, read, write}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_bus_addr", {12'd0, bus_addr}, 32'd0);
    check("rst_counts", read_count | write_count, 32'd0);
    n_cmp++;
    assert (bus_data === 16'hzzzz)
    else begin n_err++; $error("FAIL rst_bus_data: got %h expected zzzz", bus_data); end

    // 1: single m0 read, cycle-exact strobes and ack
    m0_req = 1; m0_we = 0; m0_addr = 20'h00010;
    tick();
    check("t1_read_c1", {31'd0, read}, 32'd1);
    check("t1_grant", {30'd0, grant}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_addr", {12'd0, bus_addr}, 32'h10);
    check("t1_ack_early", {31'd0, m0_ack}, 32'd0);
    tick();
    check("t1_read_c2", {31'd0, read}, 32'd1);
    tick();
    check("t1_read_off", {31'd0, read}, 32'd0);
    check("t1_ack", {31'd0, m0_ack}, 32'd1);
    check("t1_rdata", {16'd0, rdata}, 32'h1234);
    m0_req = 0;
    tick();
    check("t1_ack_drop", {31'd0, m0_ack}, 32'd0);
    check("t1_read_count", read_count, 32'd1);
    check("t1_grant_idle", {30'd0, grant}, 32'd0);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // 2: simultaneous requests after reset alternate m0, m1, m0
    do_reset();
    m0_req = 1; m0_addr = 20'h00010;
    m1_req = 1; m1_addr = 20'h00100;
    wait_ack(who);
    check("t2_first", {30'd0, who}, 32'd1);
    check("t2_rdata1", {16'd0, rdata}, 32'h1234);
    wait_ack(who);
    check("t2_second", {30'd0, who}, 32'd2);
    check("t2_rdata2", {16'd0, rdata}, 32'h5555);
    wait_ack(who);
    check("t2_third", {30'd0, who}, 32'd1);
    m0_req = 0; m1_req = 0;
    tick();
    tick();
    check("t2_read_count", read_count, 32'd3);
    check("t2_idle", {31'd0, busy}, 32'd0);

    // 3: m1 locked read-modify-write beats a waiting m0
    m0_req = 1; m0_we = 0; m0_addr = 20'h00020;
    m1_req = 1; m1_we = 0; m1_lock = 1; m1_addr = 20'h00100;
    wait_ack(who);
    check("t3_m1_read", {30'd0, who}, 32'd2);
    check("t3_rdata", {16'd0, rdata}, 32'h5555);
    m1_we = 1; m1_wdata = 16'hBEEF;
    wait_ack(who);
    check("t3_m1_write", {30'd0, who}, 32'd2);
    check("t3_rdata_hold", {16'd0, rdata}, 32'h5555);
    m1_req = 0; m1_lock = 0; m1_we = 0;
    wait_ack(who);
    check("t3_m0_after", {30'd0, who}, 32'd1);
    check("t3_m0_rdata", {16'd0, rdata}, 32'h00A5);
    m0_req = 0;
    tick();
    check("t3_mem", {16'd0, mem[10'h100]}, 32'hBEEF);
    check("t3_write_count", write_count, 32'd1);

    // 4: reset in the middle of an m0 write
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 20'h00030; m0_wdata = 16'h7777;
    tick();
    check("t4_write_on", {31'd0, write}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("t4_write_off", {31'd0, write}, 32'd0);
    check("t4_grant", {30'd0, grant}, 32'd0);
    n_cmp++;
    assert (bus_data === 16'hzzzz)
    else begin n_err++; $error("FAIL t4_bus_data: got %h expected zzzz", bus_data); end
    m0_req = 0; m0_we = 0;
    tick();
    reset = 1'b0;
    who = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      who = who | {m1_ack, m0_ack};
    end
    check("t4_no_ack", {30'd0, who}, 32'd0);
    check("t4_write_count", write_count, 32'd0);

    // 5: write counter saturation, then clear winning over an increment
    force dut.write_count_q = 32'hFFFF_FFFF;
    tick();
    release dut.write_count_q;
    tick();
    check("t5_preset", write_count, 32'hFFFF_FFFF);
    m0_req = 1; m0_we = 1; m0_addr = 20'h00040; m0_wdata = 16'h1111;
    wait_ack(who);
    check("t5_ack1", {30'd0, who}, 32'd1);
    m0_req = 0;
    tick();
    check("t5_saturate", write_count, 32'hFFFF_FFFF);
    m0_req = 1;
    wait_ack(who);
    check("t5_ack2", {30'd0, who}, 32'd1);
    m0_req = 0; cnt_clear = 1;
    tick();
    cnt_clear = 0;
    check("t5_clear_wins", write_count, 32'd0);
    check("t5_mem", {16'd0, mem[10'h040]}, 32'h1111);

    // 6: m0 withdraws its request mid-access
    m0_req = 1; m0_we = 0; m0_addr = 20'h00010;
    tick();
    m0_req = 0;
    who = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m0_ack) who = who + 2'd1;
    end
    check("t6_one_ack", {30'd0, who}, 32'd1);
    check("t6_read_count", read_count, 32'd1);
    check("t6_rdata", {16'd0, rdata}, 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
